blake2s_compress_core: RTL and testbench

BLAKE2S_COMPRESS_CORE -- requirements
Module: blake2s_compress_core

---
 rtl/blake2s_compress_core.sv | 160 ++++++++++++++++
 tb/tb_blake2s_compress_core.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/blake2s_compress_core.sv
// BLAKE2s compression core: ten rounds of column/diagonal G steps over a 16-word state.
// Define BLAKE2S_CORE_HALF_G_EN to split each step into an x-half and a y-half cycle.
module blake2s_compress_core (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [255:0] h_in,
  input  logic [63:0]  t,
  input  logic         last,
  output logic [3:0]   round,
  output logic         mode,
  input  logic [31:0]  G0_m0,
  input  logic [31:0]  G0_m1,
  input  logic [31:0]  G1_m0,
  input  logic [31:0]  G1_m1,
  input  logic [31:0]  G2_m0,
  input  logic [31:0]  G2_m1,
  input  logic [31:0]  G3_m0,
  input  logic [31:0]  G3_m1,
  output logic         ready,
  output logic [255:0] h_out,
  output logic         h_valid
);

  localparam logic [255:0] IV = {32'h5BE0CD19, 32'h1F83D9AB, 32'h9B05688C, 32'h510E527F,
                                 32'hA54FF53A, 32'h3C6EF372, 32'hBB67AE85, 32'h6A09E667};

  typedef enum logic [1:0] {StIdle, StRounds, StFinal} state_e;

  state_e       state;
  logic [4:0]   ctr;
  logic [31:0]  v      [16];
  logic [31:0]  v_step [16];
  logic [255:0] h_reg;
  logic [31:0]  m0     [4];
  logic [31:0]  m1     [4];
  logic         step_end;

  assign m0[0] = G0_m0;
  assign m0[1] = G1_m0;
  assign m0[2] = G2_m0;
  assign m0[3] = G3_m0;
  assign m1[0] = G0_m1;
  assign m1[1] = G1_m1;
  assign m1[2] = G2_m1;
  assign m1[3] = G3_m1;

  assign ready = (state == StIdle);
  assign round = (state == StRounds) ? ctr[4:1] : 4'd0;
  assign mode  = (state == StRounds) ? ctr[0] : 1'b0;

  function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
    return (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  // One half of G; the second half differs only in message word and rotate amounts.
  function automatic logic [127:0] g_half(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d,
                                          input logic [31:0] m, input logic second);
    logic [31:0] na, nb, nc, nd;
    na = a + b + m;
    nd = rotr(d ^ na, second ? 5'd8 : 5'd16);
    nc = c + nd;
    nb = rotr(b ^ nc, second ? 5'd7 : 5'd12);
    return {na, nb, nc, nd};
  endfunction

`ifdef BLAKE2S_CORE_HALF_G_EN
  logic phase;
  assign step_end = phase;
`else
  assign step_end = 1'b1;
`endif

  always_comb begin
    logic [1:0]   ii;
    logic [3:0]   ia, ib, ic, id;
    logic [127:0] r;
    ii = 2'd0;
    ia = 4'd0;
    ib = 4'd0;
    ic = 4'd0;
    id = 4'd0;
    r  = '0;
    for (int k = 0; k < 16; k++) v_step[k] = v[k];
    for (int i = 0; i < 4; i++) begin
      ii = 2'(i);
      // Diagonal step rotates rows b, c, d left by one, two and three columns.
      ia = {2'b00, ii};
      ib = {2'b01, ii + {1'b0, mode}};
      ic = {2'b10, ii + {mode, 1'b0}};
      id = {2'b11, ii + {mode, mode}};
`ifdef BLAKE2S_CORE_HALF_G_EN
      r = g_half(v[ia], v[ib], v[ic], v[id], phase ? m1[i] : m0[i], phase);
`else
      r = g_half(v[ia], v[ib], v[ic], v[id], m0[i], 1'b0);
      r = g_half(r[127:96], r[95:64], r[63:32], r[31:0], m1[i], 1'b1);
`endif
      v_step[ia] = r[127:96];
      v_step[ib] = r[95:64];
      v_step[ic] = r[63:32];
      v_step[id] = r[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= StIdle;
      ctr     <= 5'd0;
      h_reg   <= '0;
      h_out   <= '0;
      h_valid <= 1'b0;
      for (int k = 0; k < 16; k++) v[k] <= 32'd0;
`ifdef BLAKE2S_CORE_HALF_G_EN
      phase   <= 1'b0;
`endif
    end else begin
      h_valid <= 1'b0;
      case (state)
        StIdle: begin
          if (init) begin
            h_reg <= h_in;
            for (int k = 0; k < 8; k++) v[k] <= h_in[32*k +: 32];
            for (int k = 0; k < 4; k++) v[8+k] <= IV[32*k +: 32];
            v[12] <= IV[128 +: 32] ^ t[31:0];
            v[13] <= IV[160 +: 32] ^ t[63:32];
            v[14] <= IV[192 +: 32] ^ {32{last}};
            v[15] <= IV[224 +: 32];
            ctr   <= 5'd0;
            state <= StRounds;
`ifdef BLAKE2S_CORE_HALF_G_EN
            phase <= 1'b0;
`endif
          end
        end
        StRounds: begin
          for (int k = 0; k < 16; k++) v[k] <= v_step[k];
`ifdef BLAKE2S_CORE_HALF_G_EN
          phase <= ~phase;
`endif
          if (step_end) begin
            if (ctr == 5'd19) begin
              ctr   <= 5'd0;
              state <= StFinal;
            end else begin
              ctr <= ctr + 5'd1;
            end
          end
        end
        StFinal: begin
          for (int k = 0; k < 8; k++) h_out[32*k +: 32] <= h_reg[32*k +: 32] ^ v[k] ^ v[k+8];
          h_valid <= 1'b1;
          state   <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_blake2s_compress_core.sv
// Directed bench for blake2s_compress_core with a reference BLAKE2s compression model,
// a message-select stage driven from round/mode, and a per-cycle timing scoreboard.
module tb_blake2s_compress_core;

`ifdef BLAKE2S_CORE_HALF_G_EN
  localparam int CPS = 2;
`else
  localparam int CPS = 1;
`endif
  localparam int LAT = 20 * CPS + 2;

  logic         clk, reset_n, init, last, mode, ready, h_valid;
  logic [255:0] h_in, h_out;
  logic [63:0]  t;
  logic [3:0]   round;
  logic [31:0]  gm0 [4];
  logic [31:0]  gm1 [4];
  logic [31:0]  msg [16];
  logic [31:0]  mv  [16];

  int n_tests, n_fail;

  logic [31:0] ivw [8] = '{32'h6A09E667, 32'hBB67AE85, 32'h3C6EF372, 32'hA54FF53A,
                           32'h510E527F, 32'h9B05688C, 32'h1F83D9AB, 32'h5BE0CD19};

  int sigma [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11,  9, 14,  3, 12, 13,  0}};

  int gidx [8][4] = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
                      '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

  blake2s_compress_core dut (
    .clk(clk), .reset_n(reset_n), .init(init), .h_in(h_in), .t(t), .last(last),
    .round(round), .mode(mode),
    .G0_m0(gm0[0]), .G0_m1(gm1[0]), .G1_m0(gm0[1]), .G1_m1(gm1[1]),
    .G2_m0(gm0[2]), .G2_m1(gm1[2]), .G3_m0(gm0[3]), .G3_m1(gm1[3]),
    .ready(ready), .h_out(h_out), .h_valid(h_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream message-select stage.
  always_comb begin
    int rr, sel;
    rr  = 0;
    sel = 0;
    for (int i = 0; i < 4; i++) begin
      gm0[i] = 32'd0;
      gm1[i] = 32'd0;
    end
    rr = (round > 4'd9) ? 0 : int'(round);
    for (int i = 0; i < 4; i++) begin
      sel    = 2 * (i + 4 * int'(mode));
      gm0[i] = msg[sigma[rr][sel]];
      gm1[i] = msg[sigma[rr][sel+1]];
    end
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void mg(input int a, input int b, input int c, input int d,
                             input logic [31:0] x, input logic [31:0] y);
    mv[a] = mv[a] + mv[b] + x;  mv[d] = ror(mv[d] ^ mv[a], 16);
    mv[c] = mv[c] + mv[d];      mv[b] = ror(mv[b] ^ mv[c], 12);
    mv[a] = mv[a] + mv[b] + y;  mv[d] = ror(mv[d] ^ mv[a], 8);
    mv[c] = mv[c] + mv[d];      mv[b] = ror(mv[b] ^ mv[c], 7);
  endfunction

  task automatic model_compress(input logic [255:0] h, input logic [63:0] tt, input logic lst,
                                output logic [255:0] res);
    for (int k = 0; k < 8; k++) begin
      mv[k]   = h[32*k +: 32];
      mv[k+8] = ivw[k];
    end
    mv[12] = mv[12] ^ tt[31:0];
    mv[13] = mv[13] ^ tt[63:32];
    if (lst) mv[14] = ~mv[14];
    for (int r = 0; r < 10; r++)
      for (int j = 0; j < 8; j++)
        mg(gidx[j][0], gidx[j][1], gidx[j][2], gidx[j][3],
           msg[sigma[r][2*j]], msg[sigma[r][2*j+1]]);
    for (int k = 0; k < 8; k++) res[32*k +: 32] = h[32*k +: 32] ^ mv[k] ^ mv[k+8];
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timing scoreboard: one compression in flight, completion due LAT cycles after acceptance.
  int           cyc = 0, start_cyc = 0, due = 0;
  bit           busy = 1'b0, known = 1'b0;
  logic [255:0] exp_hout, exp_dig;

  always @(negedge clk) begin
    logic exp_ready, exp_valid;
    int   st, er, em;
    cyc++;
    exp_ready = 1'b1;
    if (known) begin
      exp_ready = !(busy && cyc != due);
      exp_valid = busy && cyc == due;
      er = 0;
      em = 0;
      if (busy && cyc > start_cyc && cyc <= start_cyc + 20 * CPS) begin
        st = (cyc - start_cyc - 1) / CPS;
        er = st / 2;
        em = st % 2;
      end
      chk("ready", ready, exp_ready);
      chk("h_valid", h_valid, exp_valid);
      chk("round", round, er[3:0]);
      chk("mode", mode, em[0]);
      if (exp_valid) begin
        exp_hout = exp_dig;
        busy     = 1'b0;
      end
      chk("h_out", h_out, exp_hout);
    end
    if (!reset_n) begin
      known    = 1'b1;
      busy     = 1'b0;
      exp_hout = '0;
    end else if (known && init && exp_ready) begin
      busy      = 1'b1;
      start_cyc = cyc;
      due       = cyc + LAT;
      model_compress(h_in, t, last, exp_dig);
    end
  end

  task automatic start(input logic [255:0] h, input logic [63:0] tt, input logic lst);
    @(posedge clk); #1;
    h_in = h; t = tt; last = lst; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int k = 0; k < LAT + 20; k++) begin
      @(negedge clk);
      if (h_valid === 1'b1) begin
        n = k + 1;
        break;
      end
    end
    if (n < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL valid_timeout: no h_valid within %0d cycles", LAT + 20);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [255:0] abc_h, hb, hc, pin;
  int           n;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    init    = 1'b0;
    h_in    = '0;
    t       = '0;
    last    = 1'b0;
    for (int k = 0; k < 16; k++) msg[k] = 32'd0;
    abc_h = {ivw[7], ivw[6], ivw[5], ivw[4], ivw[3], ivw[2], ivw[1], 32'h6B08E647};
    hb    = abc_h ^ {8{32'h13579BDF}};
    hc    = {abc_h[127:0], abc_h[255:128]};

    // Pin the model against the known "abc" digest.
    msg[0] = 32'h00636261;
    model_compress(abc_h, 64'd3, 1'b1, pin);
    chk("model_abc_w0", pin[31:0], 32'h8C5E8C50);
    chk("model_abc_w1", pin[63:32], 32'hE2147C32);
    chk("model_abc_w7", pin[255:224], 32'h82596786);

    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    start(abc_h, 64'd3, 1'b1);
    wait_valid(n);
    chk("abc_latency", n, LAT);
    chk("abc_w0", h_out[31:0], 32'h8C5E8C50);
    chk("abc_w1", h_out[63:32], 32'hE2147C32);
    chk("abc_w7", h_out[255:224], 32'h82596786);

    // init held through a busy period; inputs change but only the h_valid-cycle values count.
    @(posedge clk); #1;
    h_in = hb; t = 64'h40; last = 1'b0; init = 1'b1;
    @(posedge clk); #1;
    h_in = hc; t = 64'h80; last = 1'b1;
    wait_valid(n);
    chk("b2b_first_latency", n, LAT);
    @(posedge clk); #1;
    init = 1'b0; h_in = '0; t = '0; last = 1'b0;
    wait_valid(n);
    chk("b2b_spacing", n, LAT);

    // Reset mid-compression at ctr=7, with init asserted in the same cycle.
    start(abc_h, 64'd3, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    chk("pre_reset_round", round, 4'd3);
    chk("pre_reset_mode", mode, 1'b1);
    reset_n = 1'b0; init = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1; init = 1'b0;
    chk("post_reset_ready", ready, 1'b1);
    chk("post_reset_round", round, 4'd0);
    chk("post_reset_h_out", h_out, 256'd0);
    chk("post_reset_h_valid", h_valid, 1'b0);
    start(abc_h, 64'd3, 1'b1);
    wait_valid(n);
    chk("abc_after_reset_w0", h_out[31:0], 32'h8C5E8C50);

    // Counter words straddling the 32-bit boundary, non-final block, zero message.
    @(posedge clk); #1;
    for (int k = 0; k < 16; k++) msg[k] = 32'd0;
    start(abc_h, 64'hFFFFFFFF_00000001, 1'b0);
    wait_valid(n);
    chk("twrap_latency", n, LAT);

    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
